// File: rtl/s444_vec_seq.sv
// s444_vec_seq: vector sequencer and response checker for an s444-class
// benchmark netlist. It replays stored stimulus vectors one per clock onto
// the netlist inputs. Each response is compared one cycle after its vector is
// registered by the netlist. The block reports the mismatch count and the
// index of the first failing vector.
`timescale 1ns/1ps
module s444_vec_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 3,
    parameter int OW    = 6,
    parameter logic [IW-1:0] IDLE_VEC = IW'(1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             wr_valid,
    input  logic [IW+OW-1:0] wr_data,
    output logic             wr_ready,
    input  logic             clr,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    dut_in,
    input  logic [OW-1:0]    dut_obs,
    output logic [AW:0]      vec_cnt,
    output logic [AW:0]      mis_cnt,
    output logic             fail,
    output logic [AW-1:0]    first_fail
);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [DEPTH-1:0][IW-1:0] stim_mem;
    logic [DEPTH-1:0][OW-1:0] exp_mem;
    logic [AW:0]              k;          // index of next vector to issue
    logic [1:0]               vld_pipe;   // [0]: on dut_in, [1]: response on dut_obs
    logic [1:0][AW-1:0]       idx_pipe;

    logic          wr_acc;
    logic [AW:0]   cnt_wr;
    logic [IW-1:0] first_stim;
    logic          mism;
    logic          last_cmp;

    assign wr_acc     = wr_valid & wr_ready & (state != RUN);
    assign cnt_wr     = vec_cnt + (wr_acc ? ONE : '0);
    // a write accepted with start into an empty buffer must feed vector 0 directly
    assign first_stim = (vec_cnt == '0) ? wr_data[IW-1:0] : stim_mem[0];
    assign mism       = vld_pipe[1] && (dut_obs != exp_mem[idx_pipe[1]]);
    assign last_cmp   = vld_pipe[1] && ({1'b0, idx_pipe[1]} == vec_cnt - ONE);

    // vector buffer write port; contents need no reset
    always_ff @(posedge CK) begin
        if (wr_acc) begin
            stim_mem[vec_cnt[AW-1:0]] <= wr_data[IW-1:0];
            exp_mem[vec_cnt[AW-1:0]]  <= wr_data[IW+OW-1:IW];
        end
    end

    // control FSM with registered outputs, issue stage and compare stage
    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= IDLE;
            vec_cnt    <= '0;
            mis_cnt    <= '0;
            fail       <= 1'b0;
            first_fail <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b1;
            dut_in     <= IDLE_VEC;
            k          <= '0;
            vld_pipe   <= '0;
            idx_pipe   <= '0;
        end else begin
            case (state)
                RUN: begin
                    vld_pipe    <= {vld_pipe[0], 1'b0};
                    idx_pipe[1] <= idx_pipe[0];
                    if (k < vec_cnt) begin
                        dut_in      <= stim_mem[k[AW-1:0]];
                        k           <= k + ONE;
                        vld_pipe[0] <= 1'b1;
                        idx_pipe[0] <= k[AW-1:0];
                    end
                    if (mism) begin
                        mis_cnt <= mis_cnt + ONE;
                        fail    <= 1'b1;
                        if (mis_cnt == '0)
                            first_fail <= idx_pipe[1];
                    end
                    if (last_cmp) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dut_in   <= IDLE_VEC;
                        wr_ready <= (vec_cnt < DEPTH_C);
                    end
                end
                default: begin
                    vld_pipe <= '0;
                    if (clr) begin
                        state      <= IDLE;
                        vec_cnt    <= '0;
                        mis_cnt    <= '0;
                        fail       <= 1'b0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        wr_ready   <= 1'b1;
                    end else if (start) begin
                        vec_cnt    <= cnt_wr;
                        mis_cnt    <= '0;
                        fail       <= 1'b0;
                        first_fail <= '0;
                        if (cnt_wr == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            wr_ready <= 1'b1;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            wr_ready    <= 1'b0;
                            dut_in      <= first_stim;
                            k           <= ONE;
                            vld_pipe[0] <= 1'b1;
                            idx_pipe[0] <= '0;
                        end
                    end else if (wr_acc) begin
                        vec_cnt  <= cnt_wr;
                        wr_ready <= (cnt_wr < DEPTH_C);
                        state    <= IDLE;
                        done     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s444_vec_seq.sv
// Bench for s444_vec_seq: a registered golden netlist model feeds dut_obs.
// Expected stimulus and run results are queued at start and popped as the
// DUT produces them.
`timescale 1ns/1ps
module tb_s444_vec_seq;
    logic       CK = 1'b0;
    logic       RST, wr_valid, clr, start;
    logic [8:0] wr_data;
    logic       wr_ready, busy, done, fail;
    logic [2:0] dut_in;
    logic [5:0] dut_obs;
    logic [4:0] vec_cnt, mis_cnt;
    logic [3:0] first_fail;

    s444_vec_seq dut (
        .CK(CK), .RST(RST), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr(clr), .start(start), .busy(busy),
        .done(done), .dut_in(dut_in), .dut_obs(dut_obs), .vec_cnt(vec_cnt),
        .mis_cnt(mis_cnt), .fail(fail), .first_fail(first_fail)
    );

    always #5 CK = ~CK;

    function automatic logic [5:0] gold(input logic [2:0] x);
        return {x[2] ^ x[0], x[1] & x[0], x[2] | x[1], ~x[0], x[1] ^ x[2], x[0]};
    endfunction

    // benchmark model: registers its inputs, outputs a function of them
    logic [2:0] bq = 3'b000;
    always @(posedge CK) bq <= dut_in;
    assign dut_obs = gold(bq);

    typedef struct { int mis; int ff; int cyc; } res_t;
    res_t       rq[$];
    logic [2:0] sq[$];

    int n_chk = 0, n_err = 0;
    logic [2:0] m_stim[16];
    logic [5:0] m_exp[16];
    int m_cnt = 0;
    logic [2:0] sv_s[4];
    logic [5:0] sv_e[4];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] s, input logic [5:0] e);
        wr_valid = 1'b1;
        wr_data  = {e, s};
        if (wr_ready) begin
            m_stim[m_cnt] = s; m_exp[m_cnt] = e; m_cnt++;
        end
        @(negedge CK);
        wr_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge CK);
        clr = 1'b0;
        m_cnt = 0;
        chk("clr_vec_cnt", vec_cnt, 0);
    endtask

    task automatic do_run(input bit poke, input bit with_wr,
                          input logic [2:0] ws, input logic [5:0] we);
        int em, ef, bc, t, cnt0;
        res_t r;
        em = 0; ef = 0; bc = 0; t = 0;
        if (with_wr && wr_ready) begin
            m_stim[m_cnt] = ws; m_exp[m_cnt] = we; m_cnt++;
        end
        for (int i = 0; i < m_cnt; i++) begin
            if (m_exp[i] !== gold(m_stim[i])) begin
                if (em == 0) ef = i;
                em++;
            end
            sq.push_back(m_stim[i]);
        end
        r.mis = em; r.ff = ef; r.cyc = (m_cnt == 0) ? 0 : m_cnt + 1;
        rq.push_back(r);
        cnt0 = m_cnt;
        start = 1'b1;
        if (with_wr) begin wr_valid = 1'b1; wr_data = {we, ws}; end
        @(negedge CK);
        start = 1'b0; wr_valid = 1'b0;
        while (!done && t < 100) begin
            if (busy) begin
                bc++;
                chk("wr_ready_run", wr_ready, 0);
                if (sq.size() > 0) chk("dut_in", dut_in, sq.pop_front());
            end
            if (poke && bc == 2) begin
                start = 1'b1; clr = 1'b1; wr_valid = 1'b1; wr_data = 9'h1ab;
            end else begin
                start = 1'b0; clr = 1'b0; wr_valid = 1'b0;
            end
            @(negedge CK);
            t++;
        end
        start = 1'b0; clr = 1'b0; wr_valid = 1'b0;
        chk("done_seen", done, 1);
        r = rq.pop_front();
        chk("busy_cycles", bc, r.cyc);
        chk("mis_cnt", mis_cnt, r.mis);
        chk("fail", fail, (r.mis != 0) ? 1 : 0);
        chk("first_fail", first_fail, r.ff);
        chk("dut_in_idle", dut_in, 1);
        chk("busy_done", busy, 0);
        chk("vec_cnt_run", vec_cnt, cnt0);
        chk("stim_left", sq.size(), 0);
        sq.delete();
    endtask

    initial begin
        int acc;
        RST = 1'b1; wr_valid = 1'b0; clr = 1'b0; start = 1'b0; wr_data = '0;
        repeat (2) @(negedge CK);
        RST = 1'b0;
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_mis_cnt", mis_cnt, 0);
        chk("rst_first_fail", first_fail, 0);
        chk("rst_fail", fail, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_dut_in", dut_in, 1);

        // clean run of 4 golden entries
        for (int i = 0; i < 4; i++) wr(3'(i * 3 + 1), gold(3'(i * 3 + 1)));
        chk("load4_cnt", vec_cnt, 4);
        do_run(0, 0, '0, '0);

        // entries 2 and 3 corrupted
        do_clr();
        for (int i = 0; i < 4; i++) begin
            sv_s[i] = 3'(7 - i);
            sv_e[i] = (i >= 2) ? gold(sv_s[i]) ^ 6'h01 : gold(sv_s[i]);
            wr(sv_s[i], sv_e[i]);
        end
        do_run(0, 0, '0, '0);

        // start and clr together: clr wins, no run
        start = 1'b1; clr = 1'b1;
        @(negedge CK);
        start = 1'b0; clr = 1'b0; m_cnt = 0;
        chk("sc_busy", busy, 0);
        chk("sc_done", done, 0);
        chk("sc_vec_cnt", vec_cnt, 0);
        chk("sc_mis_cnt", mis_cnt, 0);
        chk("sc_fail", fail, 0);
        chk("sc_first_fail", first_fail, 0);
        @(negedge CK);
        chk("sc_busy2", busy, 0);
        for (int i = 0; i < 4; i++) wr(sv_s[i], sv_e[i]);
        do_run(0, 0, '0, '0);

        // start with an empty buffer
        do_clr();
        do_run(0, 0, '0, '0);

        // start with simultaneous write into an empty buffer
        do_clr();
        do_run(0, 1, 3'd5, gold(3'd5));

        // fill past capacity
        do_clr();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            chk("fill_wr_ready", wr_ready, (m_cnt < 16) ? 1 : 0);
            if (wr_ready) acc++;
            wr(s, (i == 5 || i == 11) ? ~gold(s) : gold(s));
        end
        chk("fill_accepts", acc, 16);
        chk("fill_vec_cnt", vec_cnt, 16);
        chk("fill_ready_low", wr_ready, 0);
        do_run(0, 0, '0, '0);

        // inputs poked mid-run are ignored
        do_run(1, 0, '0, '0);

        // reset during RUN cycle 3
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (2) @(negedge CK);
        chk("abort_busy", busy, 1);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0; m_cnt = 0;
        chk("abort_dut_in", dut_in, 1);
        chk("abort_vec_cnt", vec_cnt, 0);
        chk("abort_busy0", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wr_ready", wr_ready, 1);
        chk("abort_mis_cnt", mis_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
